ultrasonic_transmitter: RTL



---
 rtl/ultrasonic_tx_pkg.sv | 10 +
 rtl/us_carrier_gen.sv | 37 +++
 rtl/ultrasonic_transmitter.sv | 105 ++++++++++
 3 files changed

// File: rtl/ultrasonic_tx_pkg.sv
// ultrasonic_tx_pkg: shared state encoding, default Barker-13 code and length clamp
package ultrasonic_tx_pkg;
   typedef enum logic [1:0] {IDLE, ARM, TX, DEAD} state_t;
   localparam logic [31:0] BARKER13     = 32'h00001F35;
   localparam logic [5:0]  BARKER13_LEN = 6'd13;
   localparam int          MAX_CODE_LEN = 32;
   function automatic logic [5:0] clamp_len(input logic [5:0] len);
      return (len > 6'(MAX_CODE_LEN)) ? 6'(MAX_CODE_LEN) : len;
   endfunction
endpackage

// File: rtl/us_carrier_gen.sv
// us_carrier_gen: half-period/phase and carrier-cycle counters that pace the code chips
module us_carrier_gen #(
   parameter int HALF_PERIOD = 625,
   parameter int CHIP_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic phase,
   output logic cycle_wrap,
   output logic chip_wrap
);
   localparam int HW = $clog2(HALF_PERIOD);
   localparam int CW = $clog2(CHIP_CYCLES + 1);
   localparam logic [HW-1:0] HP_MAX = HW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] CC_MAX = CW'(CHIP_CYCLES - 1);
   logic [HW-1:0] r_hp;
   logic [CW-1:0] r_cyc;
   logic          r_phase;
   logic          w_hp_wrap;
   assign w_hp_wrap  = en & (r_hp == HP_MAX);
   assign cycle_wrap = w_hp_wrap & r_phase;
   assign chip_wrap  = cycle_wrap & (r_cyc == CC_MAX);
   assign phase      = r_phase;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         r_hp    <= '0;
         r_cyc   <= '0;
         r_phase <= 1'b0;
      end else if (en) begin
         r_hp <= w_hp_wrap ? '0 : r_hp + 1'b1;
         if (w_hp_wrap) r_phase <= ~r_phase;
         if (cycle_wrap) r_cyc <= chip_wrap ? '0 : r_cyc + 1'b1;
      end
   end
endmodule

// File: rtl/ultrasonic_transmitter.sv
// ultrasonic_transmitter: BPSK phase-coded burst on a complementary drive pair with
// receiver timer reset at burst start and a dead-time tail before TX_DONE.
module ultrasonic_transmitter
   import ultrasonic_tx_pkg::*;
#(
   parameter int HALF_PERIOD = 625,
   parameter int CHIP_CYCLES = 4,
   parameter int DEAD_TIME   = 5000
) (
   input  logic        SYS_CLK,
   input  logic        RST,
   input  logic        NIOS_TX_START,
   input  logic        NIOS_TX_ABORT,
   input  logic [31:0] NIOS_CODE,
   input  logic [5:0]  NIOS_CODE_LEN,
   output logic        TX_P,
   output logic        TX_N,
   output logic        TX_EN,
   output logic        TIMER_RST,
   output logic        TX_BUSY,
   output logic        TX_DONE
);
   localparam int DW = $clog2(DEAD_TIME + 1);
   localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_TIME - 1);
   state_t        r_state, w_next;
   logic          r_start_prev, r_last;
   logic [31:0]   r_code;
   logic [4:0]    r_idx;
   logic [DW-1:0] r_dead;
   logic          r_tx_p, r_tx_n, r_tx_en, r_trst, r_busy, r_done;
   logic          w_edge, w_car_en, w_phase, w_cycle_wrap, w_chip_wrap, w_p;
   logic [5:0]    w_len;
   assign w_edge   = NIOS_TX_START & ~r_start_prev;
   assign w_len    = clamp_len(NIOS_CODE_LEN);
   assign w_car_en = (r_state == ARM) || (r_state == TX);
   assign w_p      = w_phase ^ r_code[r_idx];
   // Carrier runs from ARM so it stays one cycle ahead of the registered drive.
   us_carrier_gen #(.HALF_PERIOD(HALF_PERIOD), .CHIP_CYCLES(CHIP_CYCLES)) u_car (
      .clk       (SYS_CLK),
      .rst       (RST),
      .clr       (~w_car_en),
      .en        (w_car_en),
      .phase     (w_phase),
      .cycle_wrap(w_cycle_wrap),
      .chip_wrap (w_chip_wrap)
   );
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (w_edge && !NIOS_TX_ABORT && w_len != '0) ? ARM : IDLE;
         ARM:     w_next = TX;
         TX:      w_next = r_last ? DEAD : TX;
         DEAD:    w_next = (r_dead == DEAD_MAX) ? IDLE : DEAD;
         default: w_next = IDLE;
      endcase
      if (NIOS_TX_ABORT && r_state != IDLE) w_next = IDLE;
   end
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         r_start_prev <= 1'b1;
         r_last       <= 1'b0;
         r_code       <= '0;
         r_idx        <= '0;
         r_dead       <= '0;
      end else begin
         r_start_prev <= NIOS_TX_START;
         r_last       <= (r_state == TX) && w_cycle_wrap && w_chip_wrap && (r_idx == '0);
         r_dead       <= (r_state == DEAD && w_next == DEAD) ? r_dead + 1'b1 : '0;
         if (r_state == IDLE && w_next == ARM) begin
            r_code <= NIOS_CODE;
            r_idx  <= 5'(w_len - 6'd1);
         end else if (w_chip_wrap) begin
            r_idx <= r_idx - 1'b1;
         end
      end
   end
   // Outputs are registered from the next state so every pin is a clean flop.
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         r_tx_p  <= 1'b0;
         r_tx_n  <= 1'b0;
         r_tx_en <= 1'b0;
         r_trst  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_tx_p  <= (w_next == TX) & w_p;
         r_tx_n  <= (w_next == TX) & ~w_p;
         r_tx_en <= (w_next == TX);
         r_trst  <= (w_next == ARM);
         r_busy  <= (w_next != IDLE);
         r_done  <= (r_state == DEAD) && (w_next == IDLE) && !NIOS_TX_ABORT;
      end
   end
   assign TX_P      = r_tx_p;
   assign TX_N      = r_tx_n;
   assign TX_EN     = r_tx_en;
   assign TIMER_RST = r_trst;
   assign TX_BUSY   = r_busy;
   assign TX_DONE   = r_done;
endmodule
